// File: rtl/pwm_from_count.sv
// pwm_from_count: registered PWM from a free-running counter with shadowed duty/polarity applied at counter wrap.
module pwm_from_count #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count_in,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH:0]   cfg_duty,
  input  logic             cfg_polarity,
  output logic             pwm_out,
  output logic             period_start,
  output logic             cfg_applied
);
  typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;
  state_t state, next_state;
  logic [WIDTH-1:0] prev_count;
  logic [WIDTH:0] act_duty, pend_duty, eff_duty;
  logic prev_valid, pending, act_pol, pend_pol, eff_pol, wrap, apply, raw, transfer;
  // A backwards step covers both natural rollover and an upstream counter reset.
  assign wrap      = prev_valid && (count_in < prev_count);
  assign apply     = pending && (state == IDLE || wrap);
  assign eff_duty  = apply ? pend_duty : act_duty;
  assign eff_pol   = apply ? pend_pol : act_pol;
  assign raw       = {1'b0, count_in} < eff_duty;
  assign cfg_ready = ~pending;
  assign transfer  = cfg_valid && cfg_ready;
  always_comb
    next_state = state == IDLE ? (enable ? SYNC : IDLE) :
                 state == SYNC ? (!enable ? IDLE : wrap ? RUN : SYNC) :
                 (wrap && !enable) ? IDLE : RUN;
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      prev_count   <= '0;
      prev_valid   <= 1'b0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
      cfg_applied  <= 1'b0;
      act_duty     <= '0;
      act_pol      <= 1'b0;
      pend_duty    <= '0;
      pend_pol     <= 1'b0;
      pending      <= 1'b0;
    end else begin
      state        <= next_state;
      prev_count   <= count_in;
      prev_valid   <= 1'b1;
      pwm_out      <= (next_state == RUN) ? (raw ^ eff_pol) : eff_pol;
      period_start <= wrap && (next_state == RUN);
      cfg_applied  <= apply;
      pending      <= transfer ? 1'b1 : apply ? 1'b0 : pending;
      if (apply) begin
        act_duty <= pend_duty;
        act_pol  <= pend_pol;
      end
      if (transfer) begin
        pend_duty <= cfg_duty;
        pend_pol  <= cfg_polarity;
      end
    end
  end
endmodule

// File: tb/tb_pwm_from_count.sv
// tb_pwm_from_count: randomized stimulus checked cycle by cycle against a behavioural PWM model.
module tb_pwm_from_count;
  localparam int W = 5;
  localparam int PERIOD = 1 << W;
  logic clk = 0, reset = 1, enable = 0, cfg_valid = 0, cfg_polarity = 0;
  logic [W-1:0] count_in = '0;
  logic [W:0] cfg_duty = '0;
  logic cfg_ready, pwm_out, period_start, cfg_applied;
  int checks = 0, errors = 0;
  // Model: "running" = producing periods, "armed" = waiting for the first boundary.
  int m_prev, m_act_duty, m_pend_duty, cnt;
  bit m_prev_ok, m_running, m_armed, m_act_pol, m_pend, m_pend_pol;
  bit e_pwm, e_ps, e_app;

  pwm_from_count #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .count_in(count_in), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_duty(cfg_duty),
    .cfg_polarity(cfg_polarity), .pwm_out(pwm_out), .period_start(period_start),
    .cfg_applied(cfg_applied)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @%0t: observed %b expected %b", tag, $time, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit wrap, apply, pol, nxt_run, nxt_arm, idle;
    int duty;
    if (reset) begin
      {m_prev_ok, m_running, m_armed, m_act_pol, m_pend, m_pend_pol} = '0;
      {e_pwm, e_ps, e_app} = '0;
      m_prev = 0; m_act_duty = 0; m_pend_duty = 0;
      return;
    end
    idle  = !m_running && !m_armed;
    wrap  = m_prev_ok && (int'(count_in) < m_prev);
    apply = m_pend && (idle || wrap);
    duty  = apply ? m_pend_duty : m_act_duty;
    pol   = apply ? m_pend_pol : m_act_pol;
    nxt_run = m_running ? (!wrap || enable) : (m_armed && enable && wrap);
    nxt_arm = idle ? enable : (m_armed && enable && !wrap);
    e_pwm = nxt_run ? ((int'(count_in) < duty) ^ pol) : pol;
    e_ps  = wrap && nxt_run;
    e_app = apply;
    if (apply) begin m_act_duty = m_pend_duty; m_act_pol = m_pend_pol; m_pend = 0; end
    else if (cfg_valid && !m_pend) begin m_pend = 1; m_pend_duty = int'(cfg_duty); m_pend_pol = cfg_polarity; end
    m_running = nxt_run; m_armed = nxt_arm;
    m_prev = int'(count_in); m_prev_ok = 1;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("pwm_out", pwm_out, e_pwm);
    chk("period_start", period_start, e_ps);
    chk("cfg_applied", cfg_applied, e_app);
    chk("cfg_ready", cfg_ready, !m_pend);
  endtask

  task automatic tick_count(input int jump_odds);
    cnt = (jump_odds > 0 && $urandom_range(0, jump_odds - 1) == 0) ? 0 : (cnt + 1) % PERIOD;
    count_in = W'(cnt);
  endtask

  task automatic offer(input int duty, input bit pol);
    cfg_valid = 1; cfg_duty = (W+1)'(duty); cfg_polarity = pol;
    tick_count(0); step();
    cfg_valid = 0;
  endtask

  task automatic run_free(input int n);
    for (int i = 0; i < n; i++) begin tick_count(0); step(); end
  endtask

  task automatic wait_count(input int v);
    for (int i = 0; i < PERIOD && cnt != v - 1; i++) begin tick_count(0); step(); end
  endtask

  initial begin
    cnt = 0;
    step(); step();
    chk("reset_pwm", pwm_out, 1'b0);
    chk("reset_ready", cfg_ready, 1'b1);
    reset = 0;
    offer(8, 0); run_free(3);
    enable = 1; run_free(3 * PERIOD);
    wait_count(10); offer(20, 0); run_free(2 * PERIOD);
    offer(0, 0);  run_free(2 * PERIOD);
    offer(32, 0); run_free(2 * PERIOD);
    offer(63, 0); run_free(2 * PERIOD);
    enable = 0; run_free(PERIOD);
    offer(8, 1); run_free(4); enable = 1; run_free(3 * PERIOD);
    wait_count(15); enable = 0; run_free(PERIOD + 4);
    offer(8, 0); enable = 1; run_free(2 * PERIOD);
    wait_count(12); offer(16, 1); cnt = -1; run_free(PERIOD);
    wait_count(5); offer(3, 1); reset = 1; tick_count(0); step(); reset = 0;
    chk("rst_mid_ready", cfg_ready, 1'b1);
    chk("rst_mid_pwm", pwm_out, 1'b0);
    run_free(2 * PERIOD);
    for (int i = 0; i < 4000; i++) begin
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_duty = (W+1)'($urandom_range(0, 63));
      cfg_polarity = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      reset = ($urandom_range(0, 499) == 0);
      tick_count(64);
      step();
    end
    reset = 0; cfg_valid = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
